uart_host: RTL and testbench

UART_HOST -- requirements
Module: uart_host

---
 rtl/uart_host.sv | 149 ++++++++++++++
 tb/tb_uart_host.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host.sv
// ============================================================================
//  uart_host : polls a UART-style peripheral (data/status registers) and
//              buffers traffic through small TX and RX byte FIFOs.
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module uart_host #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    output logic       o_addr,
    output logic [7:0] o_dat,
    input  logic [7:0] i_dat,
    output logic       o_we,
    output logic       o_cyc,
    input  logic [7:0] i_tx_dat,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_dat,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_overrun,
    input  logic       i_clr_overrun
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam int                PTR_W   = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0]  C_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]  C_DEPTH = PTR_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POLL   = 3'd1,
        S_DECIDE = 3'd2,
        S_RDATA  = 3'd3,
        S_WDATA  = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_status_rx;
    logic             r_status_tx_active;

    logic [7:0]       r_tx_mem [DEPTH];
    logic [7:0]       r_rx_mem [DEPTH];
    logic [PTR_W-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;

    logic             w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic             w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic [7:0]       w_tx_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_tx_full  = (r_tx_wp - r_tx_rp) == C_DEPTH;
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_rx_full  = (r_rx_wp - r_rx_rp) == C_DEPTH;
    assign w_rx_empty = (r_rx_wp == r_rx_rp);

    assign w_tx_push  = i_tx_valid && !w_tx_full;
    assign w_tx_pop   = (r_state == S_WDATA) && !w_tx_empty;
    assign w_rx_push  = (r_state == S_RDATA) && !w_rx_full;
    assign w_rx_pop   = !w_rx_empty && i_rx_ready;

    assign w_tx_head  = r_tx_mem[r_tx_rp[DEPTH_LOG2-1:0]];

    assign o_tx_ready = !w_tx_full;
    assign o_rx_valid = !w_rx_empty;
    assign o_rx_dat   = r_rx_mem[r_rx_rp[DEPTH_LOG2-1:0]];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = i_en ? S_POLL : S_IDLE;
            S_POLL:   w_state_next = S_DECIDE;
            S_DECIDE: begin
                if (!i_en)
                    w_state_next = S_IDLE;
                else if (r_status_rx && !w_rx_full)
                    w_state_next = S_RDATA;
                else if (!r_status_tx_active && !w_tx_empty)
                    w_state_next = S_WDATA;
                else
                    w_state_next = S_POLL;
            end
            S_RDATA:  w_state_next = S_POLL;
            S_WDATA:  w_state_next = S_GAP;
            S_GAP:    w_state_next = S_POLL;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state            <= S_IDLE;
            r_status_rx        <= 1'b0;
            r_status_tx_active <= 1'b0;
            o_overrun          <= 1'b0;
            o_cyc              <= 1'b0;
            o_addr             <= 1'b0;
            o_we               <= 1'b0;
            o_dat              <= 8'h00;
        end else begin
            r_state <= w_state_next;
            o_cyc   <= (w_state_next == S_POLL) || (w_state_next == S_RDATA) ||
                       (w_state_next == S_WDATA);
            o_addr  <= (w_state_next == S_POLL);
            o_we    <= (w_state_next == S_WDATA);
            o_dat   <= (w_state_next == S_WDATA) ? w_tx_head : 8'h00;

            if (r_state == S_POLL) begin
                r_status_rx        <= i_dat[0];
                r_status_tx_active <= i_dat[2];
            end

            if ((r_state == S_POLL) && i_dat[1])
                o_overrun <= 1'b1;
            else if (i_clr_overrun)
                o_overrun <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + C_ONE;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + C_ONE;
            if (w_rx_push) r_rx_wp <= r_rx_wp + C_ONE;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + C_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_tx_push)
            r_tx_mem[r_tx_wp[DEPTH_LOG2-1:0]] <= i_tx_dat;
        if (!i_reset && w_rx_push)
            r_rx_mem[r_rx_wp[DEPTH_LOG2-1:0]] <= i_dat;
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_host.sv
// ============================================================================
//  tb_uart_host : peripheral model plus TX/RX scoreboards around uart_host.
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_uart_host;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       addr;
    logic [7:0] dat_out;
    logic [7:0] dat_in;
    logic       we;
    logic       cyc;
    logic [7:0] tx_dat;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_dat;
    logic       rx_valid;
    logic       rx_ready;
    logic       overrun;
    logic       clr_overrun;

    int checks   = 0;
    int failures = 0;

    // Peripheral model: byte buffer plus status bits.
    logic [7:0] pbytes [16];
    int         prd = 0;
    int         pwr = 0;
    logic       tx_busy = 1'b0;
    logic       ovr_bit = 1'b0;
    logic [7:0] pstat, pdata;
    int         rd_cnt = 0;
    int         wr_cnt = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    always #5 clk = ~clk;

    uart_host #(.DEPTH_LOG2(2)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_en          (en),
        .o_addr        (addr),
        .o_dat         (dat_out),
        .i_dat         (dat_in),
        .o_we          (we),
        .o_cyc         (cyc),
        .i_tx_dat      (tx_dat),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_rx_dat      (rx_dat),
        .o_rx_valid    (rx_valid),
        .i_rx_ready    (rx_ready),
        .o_overrun     (overrun),
        .i_clr_overrun (clr_overrun)
    );

    always_comb begin
        pstat = {5'b0, tx_busy, ovr_bit, (prd != pwr)};
        pdata = (prd != pwr) ? pbytes[prd % 16] : 8'h00;
    end
    assign dat_in = addr ? pstat : pdata;

    // A completed data read consumes the peripheral's byte.
    always @(posedge clk)
        if (!rst && cyc && !addr && !we && (prd != pwr))
            prd <= prd + 1;

    // Every peripheral write is checked against the TX scoreboard.
    always @(negedge clk) begin
        if (cyc && !addr && !we) rd_cnt++;
        if (cyc && we) begin
            wr_cnt++;
            checks++;
            if (tx_exp.size() == 0) begin
                failures++;
                $display("FAIL tx_write_unexpected: got %h, none expected", dat_out);
            end else begin
                if (dat_out !== tx_exp[0] || addr !== 1'b0) begin
                    failures++;
                    $display("FAIL tx_write_data: got %h addr=%b, want %h addr=0",
                             dat_out, addr, tx_exp[0]);
                end
                void'(tx_exp.pop_front());
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle;
        en = 1'b0;
        repeat (5) tick;
    endtask

    task automatic load_byte(input logic [7:0] b);
        pbytes[pwr % 16] = b;
        pwr = pwr + 1;
        rx_exp.push_back(b);
    endtask

    task automatic push_tx(input logic [7:0] b, input bit accept);
        tx_dat   = b;
        tx_valid = 1'b1;
        if (accept) tx_exp.push_back(b);
        tick;
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx;
        logic [7:0] want;
        want = (rx_exp.size() != 0) ? rx_exp[0] : 8'hxx;
        checks++;
        if (rx_exp.size() == 0 || rx_valid !== 1'b1 || rx_dat !== want) begin
            failures++;
            $display("FAIL rx_pop: got valid=%b dat=%h, want valid=1 dat=%h",
                     rx_valid, rx_dat, want);
        end
        if (rx_exp.size() != 0) void'(rx_exp.pop_front());
        rx_ready = 1'b1;
        tick;
        rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; tx_valid = 1'b0; tx_dat = 8'h00;
        rx_ready = 1'b0; clr_overrun = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        checks++;
        if ({cyc, we, addr, dat_out} !== 11'b0) begin
            failures++;
            $display("FAIL reset_bus: got cyc=%b we=%b addr=%b dat=%h, want all 0",
                     cyc, we, addr, dat_out);
        end
        checks++;
        if ({rx_valid, tx_ready, overrun} !== 3'b010) begin
            failures++;
            $display("FAIL reset_flags: got rx_valid=%b tx_ready=%b ovr=%b, want 0 1 0",
                     rx_valid, tx_ready, overrun);
        end
    endtask

    task automatic test_rx;
        load_byte(8'h5A);
        en = 1'b1;
        tick;
        checks++;
        if ({cyc, addr, we} !== 3'b110) begin
            failures++;
            $display("FAIL rx_poll: got cyc/addr/we=%b, want 110", {cyc, addr, we});
        end
        tick;
        checks++;
        if ({cyc, addr, we} !== 3'b000) begin
            failures++;
            $display("FAIL rx_decide: got cyc/addr/we=%b, want 000", {cyc, addr, we});
        end
        tick;
        checks++;
        if ({cyc, addr, we, rx_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL rx_rdata: got cyc/addr/we/valid=%b, want 1000",
                     {cyc, addr, we, rx_valid});
        end
        tick;
        en = 1'b0;
        pop_rx;
        wait_idle;
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rx_empty_after_pop: got %b want 0", rx_valid);
        end
    endtask

    task automatic test_tx;
        bit found = 0;
        int base;
        push_tx(8'hA3, 1);
        tx_busy = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 12 && !found; i++) begin
            tick;
            if (we === 1'b1) found = 1;
        end
        checks++;
        if (!found || {cyc, addr, we, dat_out} !== {3'b101, 8'hA3}) begin
            failures++;
            $display("FAIL tx_wdata: got found=%0d cyc/addr/we=%b dat=%h, want 1 101 a3",
                     found, {cyc, addr, we}, dat_out);
        end
        tx_busy = 1'b1;
        tick;
        checks++;
        if ({cyc, we, dat_out} !== 10'b0) begin
            failures++;
            $display("FAIL tx_gap: got cyc=%b we=%b dat=%h, want 0 0 00", cyc, we, dat_out);
        end
        push_tx(8'h3C, 1);
        base = wr_cnt;
        repeat (12) tick;
        checks++;
        if (wr_cnt !== base) begin
            failures++;
            $display("FAIL tx_hold_busy: got %0d writes, want 0", wr_cnt - base);
        end
        tx_busy = 1'b0;
        repeat (8) tick;
        checks++;
        if (wr_cnt !== base + 1 || tx_exp.size() != 0) begin
            failures++;
            $display("FAIL tx_resume: got %0d writes pending=%0d, want 1 0",
                     wr_cnt - base, tx_exp.size());
        end
        wait_idle;
    endtask

    task automatic test_rx_full;
        int base = rd_cnt;
        rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) load_byte(8'hC0 + 8'(i));
        en = 1'b1;
        repeat (40) tick;
        checks++;
        if (rd_cnt - base !== 4 || pwr - prd !== 1) begin
            failures++;
            $display("FAIL rxfull_reads: got reads=%0d left=%0d, want 4 1",
                     rd_cnt - base, pwr - prd);
        end
        pop_rx;
        repeat (10) tick;
        checks++;
        if (rd_cnt - base !== 5 || pwr !== prd) begin
            failures++;
            $display("FAIL rxfull_fifth: got reads=%0d left=%0d, want 5 0",
                     rd_cnt - base, pwr - prd);
        end
        wait_idle;
        for (int i = 0; i < 4; i++) pop_rx;
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rxfull_drain: got valid=%b want 0", rx_valid);
        end
    endtask

    task automatic test_priority_overrun;
        bit found = 0;
        bit wrote = 0;
        int base;
        push_tx(8'h77, 1);
        load_byte(8'h11);
        ovr_bit = 1'b1;
        tx_busy = 1'b0;
        base = wr_cnt;
        en = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            tick;
            if (cyc === 1'b1 && addr === 1'b0) found = 1;
        end
        checks++;
        if (!found || we !== 1'b0) begin
            failures++;
            $display("FAIL prio_rdata_first: got found=%0d we=%b, want 1 0", found, we);
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_set: got %b want 1", overrun);
        end
        for (int i = 0; i < 10 && !wrote; i++) begin
            tick;
            if (wr_cnt != base) wrote = 1;
        end
        checks++;
        if (!wrote) begin
            failures++;
            $display("FAIL prio_wdata_after: got 0 writes, want 1");
        end
        ovr_bit = 1'b0;
        load_byte(8'h22);
        repeat (4) tick;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_sticky: got %b want 1", overrun);
        end
        clr_overrun = 1'b1;
        tick;
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clear: got %b want 0", overrun);
        end
        wait_idle;
        pop_rx;
        pop_rx;
    endtask

    task automatic test_tx_full_reset;
        bit found = 0;
        int base = wr_cnt;
        for (int i = 0; i < 4; i++) push_tx(8'h10 + 8'(i), 1);
        checks++;
        if (tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL txfull_ready: got %b want 0", tx_ready);
        end
        push_tx(8'h14, 0);
        tx_busy = 1'b0;
        en = 1'b1;
        repeat (30) tick;
        checks++;
        if (wr_cnt - base !== 4 || tx_exp.size() != 0) begin
            failures++;
            $display("FAIL txfull_drain: got writes=%0d pending=%0d, want 4 0",
                     wr_cnt - base, tx_exp.size());
        end
        wait_idle;
        push_tx(8'h20, 1);
        push_tx(8'h21, 1);
        en = 1'b1;
        for (int i = 0; i < 12 && !found; i++) begin
            tick;
            if (we === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rst_reach_wdata: got no write, want one within 12 cycles");
        end
        rst = 1'b1;
        en  = 1'b0;
        tick;
        tx_exp.delete();
        rst = 1'b0;
        checks++;
        if ({cyc, we, tx_ready, rx_valid} !== 4'b0010) begin
            failures++;
            $display("FAIL rst_mid_wdata: got cyc/we/tx_ready/rx_valid=%b, want 0010",
                     {cyc, we, tx_ready, rx_valid});
        end
        base = wr_cnt;
        en = 1'b1;
        repeat (12) tick;
        checks++;
        if (wr_cnt !== base) begin
            failures++;
            $display("FAIL rst_fifo_discard: got %0d writes, want 0", wr_cnt - base);
        end
        wait_idle;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_rx;
        test_tx;
        test_rx_full;
        test_priority_overrun;
        test_tx_full_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
